// File: rtl/mips_pkg.sv
// Shared definitions for the MEM/WB stage: opcodes, FSM states, flag bits.
// Also provides the opcode-to-class mapping used by the stage.
package mips_pkg;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b011100;
  localparam logic [5:0] OP_STORE = 6'b011101;

  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_CLEAR     = 2'd0,
    ST_RUN       = 2'd1,
    ST_LOAD_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_NOP
  } op_class_t;

  function automatic op_class_t op_class(input logic [5:0] op);
    op_class_t c;
    c = CLS_ALU;
    unique case (op)
      OP_NOP:   c = CLS_NOP;
      OP_LOAD:  c = CLS_LOAD;
      OP_STORE: c = CLS_STORE;
      default:  c = CLS_ALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous data RAM, 16-bit words, registered read.
// The array has no reset; the owning stage clears it after reset.
module dm_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: data-memory access against dm_ram and one
// registered writeback beat per retired instruction.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int RW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_ex,
  input  logic [5:0]    op_dec,
  input  logic [15:0]   ans_ex,
  input  logic [15:0]   DM_data,
  input  logic [1:0]    flag_ex,
  input  logic [RW-1:0] rd_ex,
  output logic          stall,
  output logic          wb_valid,
  output logic          wb_en,
  output logic [RW-1:0] wb_addr,
  output logic [15:0]   wb_data,
  output logic [1:0]    flag_wb,
  output logic          mem_fault
);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] ptr;
  op_class_t     cls;
  logic          accept;
  logic          in_range;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;

  logic [RW-1:0] ld_rd;
  logic [1:0]    ld_flag;
  logic          ld_fault;

  assign cls      = op_class(op_dec);
  assign accept   = valid_ex && (state == ST_RUN);
  // Full-width compare: high address bits must be zero, no aliasing.
  assign in_range = (ans_ex >> AW) == 16'd0;
  assign stall    = (state != ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_CLEAR)
        ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_CLEAR:
        if (ptr == AW'(DEPTH - 1))
          state_nx = ST_RUN;
      ST_RUN:
        if (accept && cls == CLS_LOAD)
          state_nx = ST_LOAD_WAIT;
      ST_LOAD_WAIT:
        state_nx = ST_RUN;
      default:
        state_nx = ST_CLEAR;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = ans_ex[AW-1:0];
    ram_wdata = DM_data;
    unique case (state)
      ST_CLEAR: begin
        ram_we    = !reset;
        ram_addr  = ptr;
        ram_wdata = '0;
      end
      ST_RUN:
        ram_we = !reset && accept &&
                 cls == CLS_STORE && in_range;
      default: ram_we = 1'b0;
    endcase
  end

  dm_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_rd    <= '0;
      ld_flag  <= '0;
      ld_fault <= 1'b0;
    end else if (accept && cls == CLS_LOAD) begin
      ld_rd    <= rd_ex;
      ld_flag  <= flag_ex;
      ld_fault <= !in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      flag_wb   <= '0;
      mem_fault <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      mem_fault <= 1'b0;
      if (state == ST_LOAD_WAIT) begin
        wb_valid  <= 1'b1;
        wb_en     <= 1'b1;
        wb_addr   <= ld_rd;
        wb_data   <= ld_fault ? 16'h0000 : ram_rdata;
        flag_wb   <= ld_flag;
        mem_fault <= ld_fault;
      end else if (accept) begin
        unique case (cls)
          CLS_ALU: begin
            wb_valid <= 1'b1;
            wb_en    <= 1'b1;
            wb_addr  <= rd_ex;
            wb_data  <= ans_ex;
            flag_wb  <= {flag_ex[FLAG_C], flag_ex[FLAG_Z]};
          end
          CLS_STORE: begin
            wb_valid  <= 1'b1;
            flag_wb   <= {flag_ex[FLAG_C], flag_ex[FLAG_Z]};
            mem_fault <= !in_range;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage (DEPTH=16): directed vector table, reset
// sequences and random traffic against a transaction-level model.
module tb_mem_wb_stage;
  import mips_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_ex;
  logic [5:0]  op_dec;
  logic [15:0] ans_ex;
  logic [15:0] DM_data;
  logic [1:0]  flag_ex;
  logic [2:0]  rd_ex;
  logic        stall;
  logic        wb_valid;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [1:0]  flag_wb;
  logic        mem_fault;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(DEPTH), .AW(4), .RW(3)) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex),
    .op_dec(op_dec), .ans_ex(ans_ex), .DM_data(DM_data),
    .flag_ex(flag_ex), .rd_ex(rd_ex), .stall(stall),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flag_wb(flag_wb), .mem_fault(mem_fault)
  );

  int n_pass = 0;
  int n_tot  = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  // Transaction-level reference: memory array plus pending-load state
  int          m_clear = 0;
  bit          m_ld_pend = 0;
  logic [2:0]  m_ld_rd;
  logic [1:0]  m_ld_flag;
  logic [15:0] m_ld_data;
  bit          m_ld_fault;
  logic [15:0] m_mem [DEPTH];
  bit          e_stall, e_wv, e_en, e_fault, e_rst;
  logic [2:0]  e_addr;
  logic [15:0] e_data;
  logic [1:0]  e_flag;

  task automatic model_edge();
    bit inr;
    e_wv = 0; e_en = 0; e_fault = 0; e_rst = 0;
    inr = ans_ex < DEPTH;
    if (reset) begin
      m_clear = DEPTH;
      m_ld_pend = 0;
      foreach (m_mem[i]) m_mem[i] = 16'h0;
      e_addr = 0; e_data = 0; e_flag = 0; e_rst = 1;
    end else if (m_clear > 0) begin
      m_clear--;
    end else if (m_ld_pend) begin
      e_wv = 1; e_en = 1;
      e_addr = m_ld_rd; e_data = m_ld_data;
      e_flag = m_ld_flag; e_fault = m_ld_fault;
      m_ld_pend = 0;
    end else if (valid_ex) begin
      if (op_dec == OP_NOP) begin
      end else if (op_dec == OP_STORE) begin
        if (inr) m_mem[ans_ex] = DM_data;
        e_wv = 1; e_flag = flag_ex; e_fault = !inr;
      end else if (op_dec == OP_LOAD) begin
        m_ld_pend = 1;
        m_ld_rd = rd_ex; m_ld_flag = flag_ex;
        m_ld_fault = !inr;
        m_ld_data = inr ? m_mem[ans_ex] : 16'h0;
      end else begin
        e_wv = 1; e_en = 1;
        e_addr = rd_ex; e_data = ans_ex; e_flag = flag_ex;
      end
    end
    e_stall = (m_clear > 0) || m_ld_pend;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("m_stall", stall, e_stall);
    chk("m_wb_valid", wb_valid, e_wv);
    chk("m_wb_en", wb_en, e_en);
    chk("m_fault", mem_fault, e_fault);
    if (e_wv) chk("m_flag", flag_wb, e_flag);
    if ((e_wv && e_en) || e_rst) begin
      chk("m_addr", wb_addr, e_addr);
      chk("m_data", wb_data, e_data);
    end
  endtask

  task automatic idle();
    valid_ex = 0; op_dec = OP_NOP; ans_ex = 0;
    DM_data = 0; flag_ex = 0; rd_ex = 0;
  endtask

  task automatic count_clear(string nm);
    int n;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(nm, n, DEPTH);
  endtask

  task automatic chk_reset_outs();
    chk("rst_stall", stall, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_flag", flag_wb, 0);
    chk("rst_fault", mem_fault, 0);
  endtask

  typedef struct {
    bit v; logic [5:0] op; logic [15:0] ans; logic [15:0] dmd;
    logic [1:0] flg; logic [2:0] rd;
    bit s; bit wv; bit en; bit flt;
    logic [2:0] wa; logic [15:0] wd; logic [1:0] wf;
  } vec_t;

  function automatic vec_t mk(bit v, logic [5:0] op, logic [15:0] ans,
      logic [15:0] dmd, logic [1:0] flg, logic [2:0] rd, bit s, bit wv,
      bit en, bit flt, logic [2:0] wa, logic [15:0] wd, logic [1:0] wf);
    vec_t t;
    t.v = v; t.op = op; t.ans = ans; t.dmd = dmd; t.flg = flg;
    t.rd = rd; t.s = s; t.wv = wv; t.en = en; t.flt = flt;
    t.wa = wa; t.wd = wd; t.wf = wf;
    return t;
  endfunction

  vec_t tbl [19];

  initial begin
    // load 5 after clear, ALU x3, store/load, out-of-range, stall hold, NOP
    tbl[0]  = mk(1, OP_LOAD,  16'h0005, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, OP_NOP,   0, 0, 0, 0, 0, 1, 1, 0, 1, 16'h0000, 2'b01);
    tbl[2]  = mk(1, 6'b000001, 16'h8000, 0, 2'b10, 3,
                 0, 1, 1, 0, 3, 16'h8000, 2'b10);
    tbl[3]  = mk(1, 6'b000010, 16'h0001, 0, 2'b01, 4,
                 0, 1, 1, 0, 4, 16'h0001, 2'b01);
    tbl[4]  = mk(1, 6'b100000, 16'h0002, 0, 2'b11, 5,
                 0, 1, 1, 0, 5, 16'h0002, 2'b11);
    tbl[5]  = mk(1, OP_STORE, 16'h0007, 16'h0008, 2'b00, 0,
                 0, 1, 0, 0, 0, 0, 2'b00);
    tbl[6]  = mk(1, OP_LOAD,  16'h0007, 0, 2'b10, 2, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, OP_NOP,   0, 0, 0, 0, 0, 1, 1, 0, 2, 16'h0008, 2'b10);
    tbl[8]  = mk(1, OP_STORE, 16'hC000, 16'h1234, 2'b01, 0,
                 0, 1, 0, 1, 0, 0, 2'b01);
    tbl[9]  = mk(1, OP_LOAD,  16'hC000, 0, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, OP_NOP,   0, 0, 0, 0, 0, 1, 1, 1, 6, 16'h0000, 2'b11);
    tbl[11] = mk(1, OP_LOAD,  16'h0000, 0, 2'b00, 7, 1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, OP_NOP,   0, 0, 0, 0, 0, 1, 1, 0, 7, 16'h0000, 2'b00);
    tbl[13] = mk(1, OP_LOAD,  16'h0007, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 6'b000011, 16'h0055, 0, 2'b10, 2,
                 0, 1, 1, 0, 1, 16'h0008, 2'b01);
    tbl[15] = mk(1, 6'b000011, 16'h0055, 0, 2'b10, 2,
                 0, 1, 1, 0, 2, 16'h0055, 2'b10);
    tbl[16] = mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(1, OP_NOP,   16'h0003, 0, 2'b11, 4, 0, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    idle();
    reset = 1;
    step();
    step();
    chk_reset_outs();
    reset = 0;
    count_clear("clear_len");

    for (int i = 0; i < 19; i++) begin
      valid_ex = tbl[i].v; op_dec = tbl[i].op; ans_ex = tbl[i].ans;
      DM_data = tbl[i].dmd; flag_ex = tbl[i].flg; rd_ex = tbl[i].rd;
      step();
      chk($sformatf("v%0d_stall", i), stall, tbl[i].s);
      chk($sformatf("v%0d_wb_valid", i), wb_valid, tbl[i].wv);
      chk($sformatf("v%0d_wb_en", i), wb_en, tbl[i].en);
      chk($sformatf("v%0d_fault", i), mem_fault, tbl[i].flt);
      if (tbl[i].wv) chk($sformatf("v%0d_flag", i), flag_wb, tbl[i].wf);
      if (tbl[i].wv && tbl[i].en) begin
        chk($sformatf("v%0d_addr", i), wb_addr, tbl[i].wa);
        chk($sformatf("v%0d_data", i), wb_data, tbl[i].wd);
      end
    end

    // Reset during LOAD_WAIT: the load must never retire
    valid_ex = 1; op_dec = OP_LOAD; ans_ex = 16'h0007; rd_ex = 5;
    flag_ex = 2'b11;
    step();
    chk("midld_stall", stall, 1);
    idle();
    reset = 1;
    step();
    chk_reset_outs();
    reset = 0;
    count_clear("clear_len_again");
    valid_ex = 1; op_dec = OP_LOAD; ans_ex = 16'h0007; rd_ex = 1;
    step();
    idle();
    step();
    chk("reclr_data", wb_data, 16'h0000);

    for (int c = 0; c < 600; c++) begin
      int r;
      r = $urandom_range(0, 3);
      valid_ex = ($urandom_range(0, 3) != 0);
      unique case (r)
        0: op_dec = OP_NOP;
        1: op_dec = OP_LOAD;
        2: op_dec = OP_STORE;
        default: op_dec = 6'($urandom_range(1, 27));
      endcase
      ans_ex = ($urandom_range(0, 3) != 0) ?
               16'($urandom_range(0, DEPTH - 1)) : 16'($urandom);
      DM_data = 16'($urandom);
      flag_ex = 2'($urandom);
      rd_ex   = 3'($urandom);
      step();
    end

    idle();
    step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
